// File: rtl/csr_irq_ctrl.sv
// Machine-mode trap CSRs, 64-bit cycle/instret counters and a prioritised
// interrupt entry / MRET state machine over NUM_IRQ level-sensitive lines.
module csr_irq_ctrl #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic               i_CLK,
    input  logic               i_RSTn,
    input  logic               i_CSR_EN,
    input  logic [2:0]         i_CSR_FUNCT3,
    input  logic [11:0]        i_CSR_ADDR,
    input  logic [31:0]        i_CSR_WDATA,
    input  logic [4:0]         i_CSR_ZIMM,
    output logic [31:0]        o_CSR_RDATA,
    output logic               o_ILLEGAL,
    input  logic               i_BOUNDARY,
    input  logic               i_RETIRE,
    input  logic               i_MRET,
    input  logic [31:0]        i_PC,
    input  logic [31:0]        i_INSTR,
    input  logic [NUM_IRQ-1:0] i_IRQ,
    output logic               o_IRQ_REQ,
    output logic               o_TRAP,
    output logic [31:0]        o_TRAP_PC,
    output logic [31:0]        o_MEPC
);

    localparam logic [11:0] AddrMstatus  = 12'h300;
    localparam logic [11:0] AddrMie      = 12'h304;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMscratch = 12'h340;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;
    localparam logic [11:0] AddrMtval    = 12'h343;
    localparam logic [11:0] AddrMip      = 12'h344;
    localparam logic [11:0] AddrMcycle   = 12'hB00;
    localparam logic [11:0] AddrMinstret = 12'hB02;
    localparam logic [11:0] AddrMcycleh  = 12'hB80;
    localparam logic [11:0] AddrMinstreth = 12'hB82;

    typedef enum logic {StIdle, StHandler} state_t;

    state_t state_q, state_d;

    logic               mstatus_mie_q, mstatus_mie_d;
    logic               mstatus_mpie_q, mstatus_mpie_d;
    logic [NUM_IRQ-1:0] mie_q, mie_d;
    logic [NUM_IRQ-1:0] mip_q;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mscratch_q, mscratch_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [31:0]        mtval_q, mtval_d;
    logic [63:0]        mcycle_q, mcycle_d;
    logic [63:0]        minstret_q, minstret_d;

    logic [31:0]        mie_full, mip_full, rdata, operand, wval, trap_base;
    logic               addr_ok, op_rw, op_rs, op_rc, csr_write, wr_en, read_only;
    logic [NUM_IRQ-1:0] pend;
    logic [4:0]         winner, cause;
    logic               take;
    logic               unused_pc;

    assign unused_pc = ^i_PC[1:0];

    // Read mux: old value of the addressed CSR, zero for holes.
    always_comb begin
        mie_full = '0;
        mip_full = '0;
        mie_full[16 +: NUM_IRQ] = mie_q;
        mip_full[16 +: NUM_IRQ] = mip_q;
        rdata   = '0;
        addr_ok = 1'b1;
        case (i_CSR_ADDR)
            AddrMstatus: begin
                rdata     = 32'h0000_1800;
                rdata[7]  = mstatus_mpie_q;
                rdata[3]  = mstatus_mie_q;
            end
            AddrMie:       rdata = mie_full;
            AddrMtvec:     rdata = mtvec_q;
            AddrMscratch:  rdata = mscratch_q;
            AddrMepc:      rdata = mepc_q;
            AddrMcause:    rdata = mcause_q;
            AddrMtval:     rdata = mtval_q;
            AddrMip:       rdata = mip_full;
            AddrMcycle:    rdata = mcycle_q[31:0];
            AddrMcycleh:   rdata = mcycle_q[63:32];
            AddrMinstret:  rdata = minstret_q[31:0];
            AddrMinstreth: rdata = minstret_q[63:32];
            default:       addr_ok = 1'b0;
        endcase
    end

    assign operand   = i_CSR_FUNCT3[2] ? {27'b0, i_CSR_ZIMM} : i_CSR_WDATA;
    assign op_rw     = (i_CSR_FUNCT3[1:0] == 2'b01);
    assign op_rs     = (i_CSR_FUNCT3[1:0] == 2'b10);
    assign op_rc     = (i_CSR_FUNCT3[1:0] == 2'b11);
    // Set/clear with a zero operand is a pure read.
    assign csr_write = i_CSR_EN & (op_rw | ((op_rs | op_rc) & (operand != 32'd0)));
    assign wval      = op_rw ? operand : (op_rs ? (rdata | operand) : (rdata & ~operand));
    assign read_only = (i_CSR_ADDR == AddrMip);
    assign wr_en     = csr_write & addr_ok & ~read_only;

    assign o_CSR_RDATA = rdata;
    assign o_ILLEGAL   = i_CSR_EN & (~addr_ok | (read_only & csr_write));

    // Lowest-numbered pending line wins: scan downwards so it is assigned last.
    assign pend = mip_q & mie_q;
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) winner = 5'(i);
        end
    end

    assign cause     = 5'd16 + winner;
    assign o_IRQ_REQ = (|pend) & mstatus_mie_q & (state_q == StIdle);
    assign take      = o_IRQ_REQ & i_BOUNDARY;
    assign o_TRAP    = take;
    assign trap_base = {mtvec_q[31:2], 2'b00};
    assign o_TRAP_PC = mtvec_q[0] ? (trap_base + {25'b0, cause, 2'b00}) : trap_base;
    assign o_MEPC    = mepc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (take)   state_d = StHandler;
            StHandler: if (i_MRET) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Priority on shared CSRs: trap entry over MRET over software write.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'b0, i_RETIRE};
        if (wr_en) begin
            case (i_CSR_ADDR)
                AddrMstatus: begin
                    mstatus_mie_d  = wval[3];
                    mstatus_mpie_d = wval[7];
                end
                AddrMie:       mie_d      = wval[16 +: NUM_IRQ];
                AddrMtvec:     mtvec_d    = {wval[31:2], 1'b0, wval[0]};
                AddrMscratch:  mscratch_d = wval;
                AddrMepc:      mepc_d     = {wval[31:2], 1'b0, wval[0]};
                AddrMcause:    mcause_d   = wval;
                AddrMtval:     mtval_d    = wval;
                AddrMcycle:    mcycle_d   = {mcycle_q[63:32], wval};
                AddrMcycleh:   mcycle_d   = {wval, mcycle_q[31:0]};
                AddrMinstret:  minstret_d = {minstret_q[63:32], wval};
                AddrMinstreth: minstret_d = {wval, minstret_q[31:0]};
                default: ;
            endcase
        end
        if (i_MRET) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
        if (take) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mepc_d         = {i_PC[31:2], 2'b00};
            mtval_d        = i_INSTR;
            mcause_d       = {1'b1, 26'b0, cause};
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= RESET_MTVEC;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= i_IRQ;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Bench for csr_irq_ctrl: per-cycle comparison against a behavioural CSR model,
// plus directed literal checks on the trap/MRET/counter scenarios.
module tb_csr_irq_ctrl;

    localparam int unsigned N   = 8;
    localparam logic [31:0] MTV = 32'h0000_1000;
    localparam logic [31:0] IMPL_MASK = ((32'd1 << N) - 32'd1) << 16;

    logic          i_CLK = 1'b0;
    logic          i_RSTn = 1'b0;
    logic          i_CSR_EN = 1'b0;
    logic [2:0]    i_CSR_FUNCT3 = 3'b0;
    logic [11:0]   i_CSR_ADDR = 12'h0;
    logic [31:0]   i_CSR_WDATA = 32'h0;
    logic [4:0]    i_CSR_ZIMM = 5'h0;
    logic          i_BOUNDARY = 1'b0;
    logic          i_RETIRE = 1'b0;
    logic          i_MRET = 1'b0;
    logic [31:0]   i_PC = 32'h0;
    logic [31:0]   i_INSTR = 32'h0;
    logic [N-1:0]  i_IRQ = '0;
    logic [31:0]   o_CSR_RDATA, o_TRAP_PC, o_MEPC;
    logic          o_ILLEGAL, o_IRQ_REQ, o_TRAP;

    csr_irq_ctrl #(.NUM_IRQ(N), .RESET_MTVEC(MTV)) dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_CSR_EN(i_CSR_EN), .i_CSR_FUNCT3(i_CSR_FUNCT3),
        .i_CSR_ADDR(i_CSR_ADDR), .i_CSR_WDATA(i_CSR_WDATA), .i_CSR_ZIMM(i_CSR_ZIMM),
        .o_CSR_RDATA(o_CSR_RDATA), .o_ILLEGAL(o_ILLEGAL), .i_BOUNDARY(i_BOUNDARY),
        .i_RETIRE(i_RETIRE), .i_MRET(i_MRET), .i_PC(i_PC), .i_INSTR(i_INSTR), .i_IRQ(i_IRQ),
        .o_IRQ_REQ(o_IRQ_REQ), .o_TRAP(o_TRAP), .o_TRAP_PC(o_TRAP_PC), .o_MEPC(o_MEPC)
    );

    always #10 i_CLK = ~i_CLK;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural CSR values held as full 32/64-bit words.
    logic [31:0] m_mst, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
    logic [63:0] m_cyc, m_ret;
    bit          m_hnd;

    function automatic logic [31:0] m_read(input logic [11:0] a, output bit ok);
        ok = 1'b1;
        case (a)
            12'h300: return 32'h1800 | m_mst;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ret[31:0];
            12'hB82: return m_ret[63:32];
            default: begin ok = 1'b0; return 32'h0; end
        endcase
    endfunction

    function automatic logic [31:0] m_operand();
        return i_CSR_FUNCT3[2] ? {27'b0, i_CSR_ZIMM} : i_CSR_WDATA;
    endfunction

    function automatic bit m_is_write();
        logic [1:0] k;
        k = i_CSR_FUNCT3[1:0];
        return i_CSR_EN && (k == 2'b01 || ((k == 2'b10 || k == 2'b11) && m_operand() != 0));
    endfunction

    function automatic bit m_req();
        return ((m_mip & m_mie) != 0) && m_mst[3] && !m_hnd;
    endfunction

    function automatic int m_cause();
        int c;
        logic [31:0] p;
        c = 0;
        p = m_mip & m_mie;
        for (int i = 31; i >= 16; i--) if (p[i]) c = i;
        return c;
    endfunction

    function automatic logic [31:0] m_trap_pc();
        logic [31:0] base;
        base = m_mtvec & 32'hFFFF_FFFC;
        return m_mtvec[0] ? base + 32'(4 * m_cause()) : base;
    endfunction

    always @(posedge i_CLK) begin : model
        logic [31:0] rv, op, nv, n_mst, n_mie, n_mtvec, n_scr, n_mepc, n_mcause, n_mtval;
        logic [63:0] n_cyc, n_ret;
        bit ok, take, n_hnd;
        if (!i_RSTn) begin
            m_mst = 0; m_mie = 0; m_mtvec = MTV; m_mscratch = 0; m_mepc = 0;
            m_mcause = 0; m_mtval = 0; m_mip = 0; m_cyc = 0; m_ret = 0; m_hnd = 0;
        end else begin
            rv = m_read(i_CSR_ADDR, ok);
            op = m_operand();
            case (i_CSR_FUNCT3[1:0])
                2'b01:   nv = op;
                2'b10:   nv = rv | op;
                default: nv = rv & ~op;
            endcase
            take = m_req() && i_BOUNDARY;
            n_mst = m_mst; n_mie = m_mie; n_mtvec = m_mtvec; n_scr = m_mscratch;
            n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval; n_hnd = m_hnd;
            n_cyc = m_cyc + 1;
            n_ret = m_ret + 64'(i_RETIRE);
            if (m_is_write() && ok && i_CSR_ADDR != 12'h344) begin
                case (i_CSR_ADDR)
                    12'h300: n_mst = nv & 32'h88;
                    12'h304: n_mie = nv & IMPL_MASK;
                    12'h305: n_mtvec = nv & ~32'h2;
                    12'h340: n_scr = nv;
                    12'h341: n_mepc = nv & ~32'h2;
                    12'h342: n_mcause = nv;
                    12'h343: n_mtval = nv;
                    12'hB00: n_cyc = {m_cyc[63:32], nv};
                    12'hB80: n_cyc = {nv, m_cyc[31:0]};
                    12'hB02: n_ret = {m_ret[63:32], nv};
                    default: n_ret = {nv, m_ret[31:0]};
                endcase
            end
            if (i_MRET) begin
                n_mst = 32'h80 | (m_mst[7] ? 32'h8 : 32'h0);
                n_hnd = 0;
            end
            if (take) begin
                n_mst = m_mst[3] ? 32'h80 : 32'h0;
                n_mepc = i_PC & 32'hFFFF_FFFC;
                n_mtval = i_INSTR;
                n_mcause = 32'h8000_0000 | 32'(m_cause());
                n_hnd = 1;
            end
            m_mst = n_mst; m_mie = n_mie; m_mtvec = n_mtvec; m_mscratch = n_scr;
            m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval; m_hnd = n_hnd;
            m_cyc = n_cyc; m_ret = n_ret;
            m_mip = (32'(i_IRQ) << 16) & IMPL_MASK;
        end
    end

    always @(negedge i_CLK) begin : compare
        logic [31:0] rv;
        bit ok, ill, trap;
        if (chk_on) begin
            rv   = m_read(i_CSR_ADDR, ok);
            ill  = i_CSR_EN && (!ok || (i_CSR_ADDR == 12'h344 && m_is_write()));
            trap = m_req() && i_BOUNDARY;
            chk("rdata", o_CSR_RDATA, ok ? rv : 32'h0);
            chk("illegal", 32'(o_ILLEGAL), 32'(ill));
            chk("irq_req", 32'(o_IRQ_REQ), 32'(m_req()));
            chk("trap", 32'(o_TRAP), 32'(trap));
            chk("mepc_out", o_MEPC, m_mepc);
            if (trap) chk("trap_pc", o_TRAP_PC, m_trap_pc());
        end
    end

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic csr(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] wd,
                       input logic [4:0] zi);
        i_CSR_EN = 1'b1; i_CSR_FUNCT3 = f3; i_CSR_ADDR = a; i_CSR_WDATA = wd; i_CSR_ZIMM = zi;
        step();
        i_CSR_EN = 1'b0;
    endtask

    task automatic peek(input logic [11:0] a, input logic [31:0] exp, input string name);
        i_CSR_EN = 1'b0;
        i_CSR_ADDR = a;
        #1;
        chk(name, o_CSR_RDATA, exp);
    endtask

    initial begin
        step(); step();
        chk_on = 1'b1;
        step();
        i_RSTn = 1'b1;
        step(); step(); step();
        peek(12'h305, MTV, "reset_mtvec");
        peek(12'hB00, 32'd3, "mcycle_since_reset");
        peek(12'h300, 32'h1800, "reset_mstatus");

        // mip is read-only; unimplemented addresses are illegal
        i_IRQ = 8'h80;
        step();
        i_CSR_EN = 1'b1; i_CSR_FUNCT3 = 3'b001; i_CSR_ADDR = 12'h344; i_CSR_WDATA = '1;
        #1 chk("mip_rw_illegal", 32'(o_ILLEGAL), 32'd1);
        step();
        i_CSR_EN = 1'b0;
        peek(12'h344, 32'h0080_0000, "mip_unchanged");
        i_CSR_EN = 1'b1; i_CSR_FUNCT3 = 3'b111; i_CSR_ADDR = 12'h344; i_CSR_ZIMM = 5'd0;
        #1 chk("mip_rci0_legal", 32'(o_ILLEGAL), 32'd0);
        i_CSR_FUNCT3 = 3'b010; i_CSR_ADDR = 12'h123; i_CSR_WDATA = 32'h0;
        #1 chk("unimpl_illegal", 32'(o_ILLEGAL), 32'd1);
        step();
        i_CSR_EN = 1'b0;
        i_IRQ = '0;

        // Direct-mode trap on line 0 with line 2 also high
        csr(3'b110, 12'h300, 32'h0, 5'd8);
        csr(3'b010, 12'h304, 32'h0001_0004, 5'd0);
        peek(12'h304, 32'h0001_0000, "mie_impl_bits");
        i_IRQ = 8'h05; i_PC = 32'h100; i_INSTR = 32'hDEAD_BEEF; i_BOUNDARY = 1'b1;
        step();
        chk("trap_pulse", 32'(o_TRAP), 32'd1);
        chk("trap_pc_direct", o_TRAP_PC, MTV);
        step();
        i_BOUNDARY = 1'b0;
        chk("trap_single_cycle", 32'(o_TRAP), 32'd0);
        peek(12'h342, 32'h8000_0010, "mcause_l0");
        peek(12'h341, 32'h0000_0100, "mepc_l0");
        peek(12'h300, 32'h0000_1880, "mstatus_in_handler");
        peek(12'h343, 32'hDEAD_BEEF, "mtval_l0");
        i_IRQ = '0; i_MRET = 1'b1;
        step();
        i_MRET = 1'b0;
        peek(12'h300, 32'h0000_1888, "mstatus_after_mret");

        // Vectored mode, line 2
        csr(3'b001, 12'h305, 32'h0000_0201, 5'd0);
        csr(3'b010, 12'h304, 32'h0004_0000, 5'd0);
        i_IRQ = 8'h04; i_PC = 32'h204; i_BOUNDARY = 1'b1;
        step();
        chk("vec_trap", 32'(o_TRAP), 32'd1);
        chk("vec_trap_pc", o_TRAP_PC, 32'h0000_0248);
        step();
        i_BOUNDARY = 1'b0;
        peek(12'h342, 32'h8000_0012, "mcause_l2");

        // No nesting inside the handler even with MIE set again
        csr(3'b110, 12'h300, 32'h0, 5'd8);
        csr(3'b010, 12'h304, 32'h0002_0000, 5'd0);
        i_IRQ = 8'h02; i_BOUNDARY = 1'b1;
        step(); step();
        chk("no_nest_req", 32'(o_IRQ_REQ), 32'd0);
        chk("no_nest_trap", 32'(o_TRAP), 32'd0);
        i_MRET = 1'b1;
        step();
        i_MRET = 1'b0;
        peek(12'h300, 32'h0000_1888, "mstatus_mret2");
        chk("retrap_after_mret", 32'(o_TRAP), 32'd1);
        chk("retrap_pc", o_TRAP_PC, 32'h0000_0244);
        step();
        i_BOUNDARY = 1'b0; i_IRQ = '0;
        peek(12'h342, 32'h8000_0011, "mcause_l1");
        i_MRET = 1'b1;
        step();
        i_MRET = 1'b0;

        // Counters: wrap, retire count, write beats increment
        csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd0);
        csr(3'b001, 12'hB80, 32'hFFFF_FFFF, 5'd0);
        step();
        peek(12'hB00, 32'h0, "mcycle_lo_wrap");
        peek(12'hB80, 32'h0, "mcycle_hi_wrap");
        i_RETIRE = 1'b1;
        step(); step(); step();
        i_RETIRE = 1'b0;
        peek(12'hB02, 32'd3, "minstret_3");
        peek(12'hB82, 32'd0, "minstret_hi");
        i_RETIRE = 1'b1;
        csr(3'b001, 12'hB02, 32'd10, 5'd0);
        i_RETIRE = 1'b0;
        peek(12'hB02, 32'd10, "minstret_write_wins");
        csr(3'b001, 12'h341, 32'h0000_0403, 5'd0);
        peek(12'h341, 32'h0000_0401, "mepc_bit1_cleared");

        // Trap entry beats a same-cycle mepc write
        i_IRQ = 8'h01;
        step();
        i_CSR_EN = 1'b1; i_CSR_FUNCT3 = 3'b001; i_CSR_ADDR = 12'h341; i_CSR_WDATA = 32'h400;
        i_PC = 32'h80; i_BOUNDARY = 1'b1;
        #1 chk("trap_vs_write", 32'(o_TRAP), 32'd1);
        step();
        i_CSR_EN = 1'b0; i_BOUNDARY = 1'b0; i_IRQ = '0;
        peek(12'h341, 32'h0000_0080, "mepc_trap_wins");

        // Reset inside the handler
        i_RSTn = 1'b0;
        step();
        i_RSTn = 1'b1;
        peek(12'h300, 32'h0000_1800, "mstatus_after_reset");
        peek(12'h305, MTV, "mtvec_after_reset");
        chk("req_after_reset", 32'(o_IRQ_REQ), 32'd0);
        csr(3'b110, 12'h300, 32'h0, 5'd8);
        csr(3'b010, 12'h304, 32'h0001_0000, 5'd0);
        i_IRQ = 8'h01; i_BOUNDARY = 1'b1;
        step();
        chk("idle_after_reset", 32'(o_TRAP), 32'd1);
        step();
        i_BOUNDARY = 1'b0; i_IRQ = '0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
